// File: rtl/dso_pkg.sv
// Shared definitions for the DSO SPI slave-select arbiter.
package dso_pkg;

  // Slave-select codes decoded at top level into the individual ss_n lines
  localparam logic [2:0] SS_TRIG = 3'd0;
  localparam logic [2:0] SS_CH1  = 3'd1;
  localparam logic [2:0] SS_CH2  = 3'd2;
  localparam logic [2:0] SS_CH3  = 3'd3;
  localparam logic [2:0] SS_EEP  = 3'd4;
  localparam logic [2:0] SS_NONE = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StGap
  } arb_state_t;

  // Codes above SS_EEP have no slave behind them
  function automatic logic ss_valid(input logic [2:0] code);
    return code <= SS_EEP;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [PW-1:0]      idx,
  output logic               valid
);

  localparam logic [PW:0] NREQ_W = (PW+1)'(NUM_REQ);

  // Scan candidates ptr, ptr+1, ... mod NUM_REQ; keep the first hit
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] cand;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      cand = sum[PW-1:0];
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/spi_ss_arbiter.sv
// Shares one SPI master between NUM_REQ requesters, one 16-bit frame at a time.
module spi_ss_arbiter
  import dso_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned GAP_CYC = 4,
  parameter int unsigned TO_CYC  = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_cmd,
  input  logic [3*NUM_REQ-1:0]   req_ss,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     req_done,
  output logic                   req_err,
  output logic [15:0]            resp_data,
  output logic                   busy,
  output logic                   wrt_SPI,
  output logic [15:0]            SPI_cmd,
  input  logic                   SPI_done,
  input  logic [15:0]            SPI_data,
  output logic [2:0]             ss
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW = $clog2(TO_CYC);
  localparam int unsigned GW = $clog2(GAP_CYC + 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TO_CYC - 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYC - 1);
  localparam logic [PW-1:0] LAST_REQ = PW'(NUM_REQ - 1);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d, done_q, done_d;
  logic                err_q, err_d, wrt_q, wrt_d;
  logic [15:0]         resp_q, resp_d, cmd_q, cmd_d;
  logic [2:0]          ss_q, ss_d;
  logic [PW-1:0]       ptr_q, ptr_d, win_q, win_d;
  logic [TW-1:0]       to_q, to_d;
  logic [GW-1:0]       gap_q, gap_d;

  logic [NUM_REQ-1:0]  win_oh;
  logic [PW-1:0]       win_idx;
  logic                win_vld;
  logic [15:0]         win_cmd;
  logic [2:0]          win_ss;

  // A requester still holding req in its bad-code done cycle must not win again
  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req    (req & ~gnt_q),
    .ptr    (ptr_q),
    .onehot (win_oh),
    .idx    (win_idx),
    .valid  (win_vld)
  );

  assign win_cmd = req_cmd[16*win_idx +: 16];
  assign win_ss  = req_ss[3*win_idx +: 3];

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    wrt_d   = 1'b0;
    resp_d  = resp_q;
    cmd_d   = cmd_q;
    ss_d    = ss_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    to_d    = to_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        gnt_d = '0;
        if (win_vld) begin
          gnt_d = win_oh;
          win_d = win_idx;
          if (!ss_valid(win_ss)) begin
            // No slave to talk to: report the error, leave ss where it was
            done_d = win_oh;
            err_d  = 1'b1;
            ptr_d  = (win_idx == LAST_REQ) ? '0 : win_idx + 1'b1;
          end else begin
            cmd_d   = win_cmd;
            ss_d    = win_ss;
            state_d = StLaunch;
          end
        end
      end
      StLaunch: begin
        wrt_d   = 1'b1;
        to_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        if (SPI_done) begin
          resp_d  = SPI_data;
          done_d  = gnt_q;
          gap_d   = '0;
          state_d = StGap;
        end else if (to_q == TO_MAX) begin
          done_d  = gnt_q;
          err_d   = 1'b1;
          gap_d   = '0;
          state_d = StGap;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      StGap: begin
        // ss deliberately keeps its value so the ss_n decode never glitches
        if (gap_q == GAP_MAX) begin
          gnt_d   = '0;
          ptr_d   = (win_q == LAST_REQ) ? '0 : win_q + 1'b1;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      wrt_q   <= 1'b0;
      resp_q  <= '0;
      cmd_q   <= '0;
      ss_q    <= SS_NONE;
      ptr_q   <= '0;
      win_q   <= '0;
      to_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wrt_q   <= wrt_d;
      resp_q  <= resp_d;
      cmd_q   <= cmd_d;
      ss_q    <= ss_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      to_q    <= to_d;
      gap_q   <= gap_d;
    end
  end

  assign gnt       = gnt_q;
  assign req_done  = done_q;
  assign req_err   = err_q;
  assign resp_data = resp_q;
  assign wrt_SPI   = wrt_q;
  assign SPI_cmd   = cmd_q;
  assign ss        = ss_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_spi_ss_arbiter.sv
// Self-checking bench for spi_ss_arbiter: scenario tasks with a completion scoreboard.
module tb_spi_ss_arbiter;

  localparam int NUM_REQ = 3;
  localparam int GAP_CYC = 4;
  localparam int TO_CYC  = 4096;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] req_cmd;
  logic [3*NUM_REQ-1:0]  req_ss;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    req_done;
  logic                  req_err;
  logic [15:0]           resp_data;
  logic                  busy;
  logic                  wrt_SPI;
  logic [15:0]           SPI_cmd;
  logic                  SPI_done;
  logic [15:0]           SPI_data;
  logic [2:0]            ss;

  typedef struct {
    logic [2:0]  done;
    logic        err;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] resp_exp;

  spi_ss_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GAP_CYC (GAP_CYC),
    .TO_CYC  (TO_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_cmd   (req_cmd),
    .req_ss    (req_ss),
    .gnt       (gnt),
    .req_done  (req_done),
    .req_err   (req_err),
    .resp_data (resp_data),
    .busy      (busy),
    .wrt_SPI   (wrt_SPI),
    .SPI_cmd   (SPI_cmd),
    .SPI_done  (SPI_done),
    .SPI_data  (SPI_data),
    .ss        (ss)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wrt(input int budget, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < budget) begin
      step();
      cyc++;
      if (wrt_SPI === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int c = 0;
    while (busy !== 1'b0 && c < budget) begin
      step();
      c++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    req      = '0;
    req_cmd  = '0;
    req_ss   = '0;
    SPI_done = 1'b0;
    SPI_data = '0;
    resp_exp = 16'h0000;
    #12;
    n_checks++;
    if (gnt !== 3'b000 || req_done !== 3'b000 || req_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: gnt=%b done=%b err=%b, expected 000 000 0", gnt, req_done, req_err);
    end
    n_checks++;
    if (resp_data !== 16'h0000 || SPI_cmd !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data: resp=%h cmd=%h, expected 0000 0000", resp_data, SPI_cmd);
    end
    n_checks++;
    if (busy !== 1'b0 || wrt_SPI !== 1'b0 || ss !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_io: busy=%b wrt=%b ss=%b, expected 0 0 111", busy, wrt_SPI, ss);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    exp_t e;
    bit   ok;
    req_cmd[15:0] = 16'hA5C3;
    req_ss[2:0]   = 3'd1;
    req           = 3'b001;
    step();
    n_checks++;
    if (wrt_SPI !== 1'b0) begin
      n_fail++;
      $display("FAIL single_wrt_early: wrt=%b after 1 clk, expected 0", wrt_SPI);
    end
    step();
    n_checks++;
    if (wrt_SPI !== 1'b1) begin
      n_fail++;
      $display("FAIL single_wrt_latency: wrt=%b after 2 clk, expected 1", wrt_SPI);
    end
    n_checks++;
    if (SPI_cmd !== 16'hA5C3 || ss !== 3'd1 || gnt !== 3'b001 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_launch: cmd=%h ss=%0d gnt=%b busy=%b, expected a5c3 1 001 1",
               SPI_cmd, ss, gnt, busy);
    end
    SPI_data = 16'h0042;
    SPI_done = 1'b1;
    sb.push_back('{done: 3'b001, err: 1'b0, data: 16'h0042});
    resp_exp = 16'h0042;
    step();
    SPI_done = 1'b0;
    req      = 3'b000;
    e = sb.pop_front();
    n_checks++;
    if (req_done !== e.done || req_err !== e.err || resp_data !== e.data) begin
      n_fail++;
      $display("FAIL single_done: done=%b err=%b data=%h, expected %b %b %h",
               req_done, req_err, resp_data, e.done, e.err, e.data);
    end
    step();
    n_checks++;
    if (req_done !== 3'b000) begin
      n_fail++;
      $display("FAIL single_done_pulse: done=%b one clk later, expected 000", req_done);
    end
    wait_idle(20, ok);
    n_checks++;
    if (!ok || gnt !== 3'b000 || ss !== 3'd1) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b gnt=%b ss=%0d, expected 0 000 1", busy, gnt, ss);
    end
  endtask

  task automatic test_contention();
    exp_t        e;
    bit          seen;
    bit          ok;
    int          c;
    int          since_done;
    int          order[4] = '{0, 1, 2, 0};
    logic [2:0]  exp_g;
    logic [15:0] exp_cmd;
    logic [15:0] d;
    // Fresh reset so the round-robin pointer starts at 0
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    resp_exp = 16'h0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_cmd[16*i +: 16] = 16'h1000 + 16'(i);
      req_ss[3*i +: 3]    = 3'(i);
    end
    req        = 3'b111;
    since_done = 100;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      c    = 0;
      while (!seen && c < 40) begin
        step();
        c++;
        since_done++;
        n_checks++;
        if (!$onehot0(gnt)) begin
          n_fail++;
          $display("FAIL contention_onehot: gnt=%b, expected at most one bit", gnt);
        end
        if (wrt_SPI === 1'b1) seen = 1'b1;
      end
      exp_g   = 3'b001 << order[k];
      exp_cmd = 16'h1000 + 16'(order[k]);
      n_checks++;
      if (!seen) begin
        n_fail++;
        $display("FAIL contention_wrt: no wrt_SPI for grant %0d, expected one", k);
      end else if (gnt !== exp_g || SPI_cmd !== exp_cmd || ss !== 3'(order[k])) begin
        n_fail++;
        $display("FAIL contention_order: grant %0d gnt=%b cmd=%h ss=%0d, expected %b %h %0d",
                 k, gnt, SPI_cmd, ss, exp_g, exp_cmd, order[k]);
      end
      n_checks++;
      if (since_done < GAP_CYC) begin
        n_fail++;
        $display("FAIL contention_gap: %0d clk from done to wrt, expected >= %0d",
                 since_done, GAP_CYC);
      end
      d        = 16'hD000 + 16'(k);
      SPI_data = d;
      SPI_done = 1'b1;
      sb.push_back('{done: exp_g, err: 1'b0, data: d});
      resp_exp = d;
      step();
      SPI_done   = 1'b0;
      since_done = 0;
      e = sb.pop_front();
      n_checks++;
      if (req_done !== e.done || req_err !== e.err || resp_data !== e.data) begin
        n_fail++;
        $display("FAIL contention_done: grant %0d done=%b err=%b data=%h, expected %b %b %h",
                 k, req_done, req_err, resp_data, e.done, e.err, e.data);
      end
    end
    req = 3'b000;
    wait_idle(20, ok);
    n_checks++;
    if (!ok || gnt !== 3'b000) begin
      n_fail++;
      $display("FAIL contention_idle: busy=%b gnt=%b, expected 0 000", busy, gnt);
    end
  endtask

  task automatic test_bad_code();
    exp_t e;
    bit   wrt_seen;
    bit   done_seen;
    int   c;
    req_ss[5:3] = 3'd6;
    req         = 3'b010;
    sb.push_back('{done: 3'b010, err: 1'b1, data: resp_exp});
    wrt_seen  = 1'b0;
    done_seen = 1'b0;
    c         = 0;
    while (!done_seen && c < 2) begin
      step();
      c++;
      if (wrt_SPI === 1'b1) wrt_seen = 1'b1;
      if (req_done !== 3'b000) done_seen = 1'b1;
    end
    req = 3'b000;
    n_checks++;
    if (!done_seen) begin
      n_fail++;
      $display("FAIL bad_done_timing: no req_done within 2 clk, expected one");
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (req_done !== e.done || req_err !== e.err || resp_data !== e.data) begin
        n_fail++;
        $display("FAIL bad_done: done=%b err=%b data=%h, expected %b %b %h",
                 req_done, req_err, resp_data, e.done, e.err, e.data);
      end
    end
    // Last real grant was requester 0 with code 0
    n_checks++;
    if (ss !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_ss_held: ss=%0d busy=%b, expected 0 0", ss, busy);
    end
    step();
    if (wrt_SPI === 1'b1) wrt_seen = 1'b1;
    n_checks++;
    if (wrt_seen || req_done !== 3'b000 || gnt !== 3'b000) begin
      n_fail++;
      $display("FAIL bad_no_wrt: wrt_seen=%b done=%b gnt=%b, expected 0 000 000",
               wrt_seen, req_done, gnt);
    end
    req_ss[5:3] = 3'd1;
  endtask

  task automatic test_timeout();
    exp_t e;
    bit   seen;
    bit   ok;
    int   c;
    req_cmd[47:32] = 16'hBEEF;
    req_ss[8:6]    = 3'd3;
    req            = 3'b100;
    sb.push_back('{done: 3'b100, err: 1'b1, data: resp_exp});
    wait_wrt(10, c, seen);
    n_checks++;
    if (!seen || SPI_cmd !== 16'hBEEF || ss !== 3'd3) begin
      n_fail++;
      $display("FAIL timeout_launch: seen=%b cmd=%h ss=%0d, expected 1 beef 3", seen, SPI_cmd, ss);
    end
    c = 0;
    while (req_done === 3'b000 && c < TO_CYC + 10) begin
      step();
      c++;
    end
    req = 3'b000;
    n_checks++;
    if (c != TO_CYC) begin
      n_fail++;
      $display("FAIL timeout_latency: req_done %0d clk after wrt, expected %0d", c, TO_CYC);
    end
    e = sb.pop_front();
    n_checks++;
    if (req_done !== e.done || req_err !== e.err || resp_data !== e.data) begin
      n_fail++;
      $display("FAIL timeout_done: done=%b err=%b data=%h, expected %b %b %h",
               req_done, req_err, resp_data, e.done, e.err, e.data);
    end
    wait_idle(20, ok);
    n_checks++;
    if (!ok || gnt !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_idle: busy=%b gnt=%b, expected 0 000", busy, gnt);
    end
  endtask

  task automatic test_mid_op();
    exp_t e;
    bit   seen;
    bit   ok;
    int   c;
    // Requester drops req while the frame is in flight
    req_cmd[15:0] = 16'h1234;
    req_ss[2:0]   = 3'd2;
    req           = 3'b001;
    wait_wrt(10, c, seen);
    req = 3'b000;
    repeat (3) step();
    SPI_data = 16'h5678;
    SPI_done = 1'b1;
    sb.push_back('{done: 3'b001, err: 1'b0, data: 16'h5678});
    resp_exp = 16'h5678;
    step();
    SPI_done = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (!seen || req_done !== e.done || req_err !== e.err || resp_data !== e.data) begin
      n_fail++;
      $display("FAIL midop_req_drop: seen=%b done=%b err=%b data=%h, expected 1 %b %b %h",
               seen, req_done, req_err, resp_data, e.done, e.err, e.data);
    end
    wait_idle(20, ok);
    // Reset lands in the middle of WAIT
    req_cmd[31:16] = 16'h4321;
    req_ss[5:3]    = 3'd1;
    req            = 3'b010;
    wait_wrt(10, c, seen);
    step();
    #3 rst_n = 1'b0;
    #1;
    resp_exp = 16'h0000;
    n_checks++;
    if (!seen || gnt !== 3'b000 || ss !== 3'b111 || busy !== 1'b0 || wrt_SPI !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset: seen=%b gnt=%b ss=%b busy=%b wrt=%b, expected 1 000 111 0 0",
               seen, gnt, ss, busy, wrt_SPI);
    end
    n_checks++;
    if (resp_data !== resp_exp || SPI_cmd !== 16'h0000 || req_done !== 3'b000) begin
      n_fail++;
      $display("FAIL midop_reset_data: resp=%h cmd=%h done=%b, expected %h 0000 000",
               resp_data, SPI_cmd, req_done, resp_exp);
    end
    SPI_data = 16'hFFFF;
    SPI_done = 1'b1;
    @(posedge clk);
    #1;
    SPI_done = 1'b0;
    rst_n    = 1'b1;
    // Same requester still waiting; it must be served from scratch
    wait_wrt(10, c, seen);
    n_checks++;
    if (!seen || c != 2 || gnt !== 3'b010 || SPI_cmd !== 16'h4321 || ss !== 3'd1) begin
      n_fail++;
      $display("FAIL midop_relaunch: seen=%b clk=%0d gnt=%b cmd=%h ss=%0d, expected 1 2 010 4321 1",
               seen, c, gnt, SPI_cmd, ss);
    end
    SPI_data = 16'h9ABC;
    SPI_done = 1'b1;
    sb.push_back('{done: 3'b010, err: 1'b0, data: 16'h9ABC});
    resp_exp = 16'h9ABC;
    step();
    SPI_done = 1'b0;
    req      = 3'b000;
    e = sb.pop_front();
    n_checks++;
    if (req_done !== e.done || req_err !== e.err || resp_data !== e.data) begin
      n_fail++;
      $display("FAIL midop_after_reset: done=%b err=%b data=%h, expected %b %b %h",
               req_done, req_err, resp_data, e.done, e.err, e.data);
    end
    wait_idle(20, ok);
    n_checks++;
    if (!ok || gnt !== 3'b000) begin
      n_fail++;
      $display("FAIL midop_idle: busy=%b gnt=%b, expected 0 000", busy, gnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_bad_code();
    test_timeout();
    test_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
